// File: rtl/dmem_ctrl.sv
// Data-memory controller: bridges a valid/ready load/store port onto a
// single-port synchronous SRAM with address range checking and optional response delay.

package dmem_ctrl_pkg;
    localparam int unsigned RISCV_ADDR_WIDTH = 32;
    localparam int unsigned RISCV_WORD_WIDTH = 32;
    localparam int unsigned LANES            = 4;
    localparam int unsigned CNT_W            = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        WAIT,
        RESP
    } dmem_state_t;
endpackage

module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [RISCV_ADDR_WIDTH-1:0] BASE_ADDR = 32'h0001_0000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dmem_valid_i,
    output logic                          dmem_ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0]   dmem_wdata_i,
    input  logic [LANES-1:0]              dmem_we_i,
    output logic [RISCV_WORD_WIDTH-1:0]   dmem_rdata_o,
    output logic                          dmem_err_o,
    output logic                          sram_cs_o,
    output logic [LANES-1:0]              sram_we_o,
    output logic [$clog2(DEPTH_WORDS)-1:0] sram_addr_o,
    output logic [RISCV_WORD_WIDTH-1:0]   sram_wdata_o,
    input  logic [RISCV_WORD_WIDTH-1:0]   sram_rdata_i
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    // One extra bit so BASE_ADDR + size cannot wrap around the address space.
    localparam logic [RISCV_ADDR_WIDTH:0] LIMIT =
        (RISCV_ADDR_WIDTH+1)'(BASE_ADDR) + (RISCV_ADDR_WIDTH+1)'(DEPTH_WORDS) * (RISCV_ADDR_WIDTH+1)'(4);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    dmem_state_t                 state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [RISCV_WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic [LANES-1:0]            req_we_q, req_we_d;

    logic                        ready_d;
    logic                        resp_err_d;
    logic [RISCV_WORD_WIDTH-1:0] resp_rdata_d;
    logic                        cs_d;
    logic [LANES-1:0]            swe_d;
    logic [IDX_W-1:0]            saddr_d;
    logic [RISCV_WORD_WIDTH-1:0] swdata_d;

    logic                        in_range;
    logic [IDX_W-1:0]            word_idx;
    logic                        is_read;

    assign in_range = (dmem_addr_i >= BASE_ADDR) &&
                      ((RISCV_ADDR_WIDTH+1)'(dmem_addr_i) < LIMIT);
    assign word_idx = IDX_W'((dmem_addr_i - BASE_ADDR) >> 2);
    assign is_read  = (req_we_q == '0);

    // State, request registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            req_we_q     <= '0;
            dmem_ready_o <= 1'b0;
            dmem_err_o   <= 1'b0;
            dmem_rdata_o <= '0;
            sram_cs_o    <= 1'b0;
            sram_we_o    <= '0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            req_we_q     <= req_we_d;
            dmem_ready_o <= ready_d;
            dmem_err_o   <= resp_err_d;
            dmem_rdata_o <= resp_rdata_d;
            sram_cs_o    <= cs_d;
            sram_we_o    <= swe_d;
            sram_addr_o  <= saddr_d;
            sram_wdata_o <= swdata_d;
        end
    end

    // Next state and next registered-output values; outputs are computed for
    // the state being entered so they line up with it after the edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_we_d     = req_we_q;
        ready_d      = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        cs_d         = 1'b0;
        swe_d        = '0;
        saddr_d      = sram_addr_o;
        swdata_d     = sram_wdata_o;

        unique case (state_q)
            IDLE: begin
                if (dmem_valid_i) begin
                    err_d    = !in_range;
                    req_we_d = dmem_we_i;
                    saddr_d  = word_idx;
                    swdata_d = dmem_wdata_i;
                    if (in_range) begin
                        state_d = ACCESS;
                        cs_d    = 1'b1;
                        swe_d   = dmem_we_i;
                    end else begin
                        state_d    = RESP;
                        ready_d    = 1'b1;
                        resp_err_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rdata_d = sram_rdata_i;
                if (WAIT_CYCLES > 0) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d      = RESP;
                    ready_d      = 1'b1;
                    resp_err_d   = err_q;
                    resp_rdata_d = is_read ? sram_rdata_i : '0;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    ready_d      = 1'b1;
                    resp_err_d   = err_q;
                    resp_rdata_d = is_read ? rdata_q : '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: two instances (WAIT_CYCLES 0 and 2) share the
// request port, each with its own behavioural SRAM.

module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;

    logic        ready0, err0, cs0;
    logic [31:0] rdata0, swdata0, srdata0;
    logic [3:0]  swe0;
    logic [9:0]  saddr0;

    logic        ready1, err1, cs1;
    logic [31:0] rdata1, swdata1, srdata1;
    logic [3:0]  swe1;
    logic [9:0]  saddr1;

    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];

    int n_checks;
    int n_pass;

    // Results of the most recent txn call.
    int          lat0, lat1, rc0, nc0, nc1;
    logic [31:0] rd0, rd1;
    logic        er0, er1;
    logic        cs_k1;
    logic [9:0]  sa_k1;
    logic [31:0] swd_k1;
    logic [3:0]  swe_k1;

    dmem_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .dmem_valid_i(valid), .dmem_ready_o(ready0),
        .dmem_addr_i(addr), .dmem_wdata_i(wdata), .dmem_we_i(we),
        .dmem_rdata_o(rdata0), .dmem_err_o(err0),
        .sram_cs_o(cs0), .sram_we_o(swe0), .sram_addr_o(saddr0),
        .sram_wdata_o(swdata0), .sram_rdata_i(srdata0)
    );

    dmem_ctrl #(.WAIT_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .dmem_valid_i(valid), .dmem_ready_o(ready1),
        .dmem_addr_i(addr), .dmem_wdata_i(wdata), .dmem_we_i(we),
        .dmem_rdata_o(rdata1), .dmem_err_o(err1),
        .sram_cs_o(cs1), .sram_we_o(swe1), .sram_addr_o(saddr1),
        .sram_wdata_o(swdata1), .sram_rdata_i(srdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        srdata0 = 32'h0;
        srdata1 = 32'h0;
    end

    // Synchronous SRAM models: read data appears the cycle after chip select.
    always @(posedge clk) begin
        if (cs0) begin
            for (int b = 0; b < 4; b++)
                if (swe0[b]) mem0[saddr0][b*8 +: 8] <= swdata0[b*8 +: 8];
            srdata0 <= mem0[saddr0];
        end
        if (cs1) begin
            for (int b = 0; b < 4; b++)
                if (swe1[b]) mem1[saddr1][b*8 +: 8] <= swdata1[b*8 +: 8];
            srdata1 <= mem1[saddr1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One request presented for a single edge, inputs scrambled afterwards;
    // cycle k is the k-th falling edge after the accepting edge.
    task automatic txn(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        valid = 1'b1; addr = a; we = w; wdata = d;
        @(posedge clk);
        #1;
        valid = 1'b0; addr = ~a; we = ~w; wdata = ~d;
        lat0 = 0; lat1 = 0; rc0 = 0; nc0 = 0; nc1 = 0;
        rd0 = 'x; rd1 = 'x; er0 = 1'bx; er1 = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cs_k1 = cs0; sa_k1 = saddr0; swd_k1 = swdata0; swe_k1 = swe0;
            end
            if (ready0) begin
                rc0++;
                if (lat0 == 0) begin lat0 = k; rd0 = rdata0; er0 = err0; end
            end
            if (ready1 && lat1 == 0) begin lat1 = k; rd1 = rdata1; er1 = err1; end
            if (cs0) nc0++;
            if (cs1) nc1++;
        end
    endtask

    logic [15:0] mask_r, mask_c;
    int          rst_readies;

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; valid = 1'b0; addr = 32'h0; wdata = 32'h0; we = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_ctl", 32'({ready0, err0, cs0, swe0}), 32'h0);
        check("rst_rdata", rdata0, 32'h0);
        check("rst_sram", 32'({saddr0, swdata0 != 32'h0}), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-word write
        txn(32'h0001_0004, 4'b1111, 32'hDEAD_BEEF);
        check("wr_cs_k1", 32'(cs_k1), 32'h1);
        check("wr_sram_addr", 32'(sa_k1), 32'h1);
        check("wr_sram_wdata", swd_k1, 32'hDEAD_BEEF);
        check("wr_sram_we", 32'(swe_k1), 32'hF);
        check("wr_lat0", 32'(lat0), 32'd3);
        check("wr_lat1", 32'(lat1), 32'd5);
        check("wr_err", 32'(er0), 32'h0);
        check("wr_rdata", rd0, 32'h0);
        check("wr_ready_pulses", 32'(rc0), 32'd1);
        check("wr_cs_count", 32'(nc0), 32'd1);

        // Read back, both latencies
        txn(32'h0001_0004, 4'b0000, 32'h0);
        check("rd_lat0", 32'(lat0), 32'd3);
        check("rd_data0", rd0, 32'hDEAD_BEEF);
        check("rd_lat1", 32'(lat1), 32'd5);
        check("rd_data1", rd1, 32'hDEAD_BEEF);
        check("rd_sram_we", 32'(swe_k1), 32'h0);

        // Single-lane write at unaligned byte address
        txn(32'h0001_0006, 4'b0010, 32'h0000_AA00);
        check("bw_sram_addr", 32'(sa_k1), 32'h1);
        check("bw_sram_we", 32'(swe_k1), 32'h2);
        txn(32'h0001_0004, 4'b0000, 32'h0);
        check("bw_rd0", rd0, 32'hDEAD_AAEF);
        check("bw_rd1", rd1, 32'hDEAD_AAEF);

        // Out-of-range below and above
        txn(32'h0000_FFFC, 4'b0000, 32'h0);
        check("oor_lo_lat0", 32'(lat0), 32'd1);
        check("oor_lo_lat1", 32'(lat1), 32'd1);
        check("oor_lo_err", 32'({er0, er1}), 32'h3);
        check("oor_lo_rdata", rd0, 32'h0);
        check("oor_lo_cs", 32'(nc0 + nc1), 32'd0);
        txn(32'h0001_1000, 4'b1111, 32'h5555_5555);
        check("oor_hi_lat0", 32'(lat0), 32'd1);
        check("oor_hi_err", 32'(er0), 32'h1);
        check("oor_hi_rdata", rd0, 32'h0);
        check("oor_hi_cs", 32'(nc0 + nc1), 32'd0);

        // Last in-range word
        txn(32'h0001_0FFC, 4'b0000, 32'h0);
        check("top_lat0", 32'(lat0), 32'd3);
        check("top_err", 32'(er0), 32'h0);
        check("top_sram_addr", 32'(sa_k1), 32'h3FF);

        // Valid held high across three back-to-back reads
        @(negedge clk);
        valid = 1'b1; addr = 32'h0001_0004; we = 4'b0000; wdata = 32'h0;
        mask_r = '0; mask_c = '0;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ready0) begin
                mask_r[k] = 1'b1;
                check("b2b_rdata", rdata0, 32'hDEAD_AAEF);
            end
            if (cs0) mask_c[k] = 1'b1;
        end
        valid = 1'b0;
        check("b2b_ready_mask", 32'(mask_r), 32'h0888);
        check("b2b_cs_mask", 32'(mask_c), 32'h0222);
        repeat (10) @(negedge clk);

        // Reset asserted while a write is in ACCESS
        @(negedge clk);
        valid = 1'b1; addr = 32'h0001_0010; we = 4'b1111; wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        check("arst_cs_before", 32'(cs0), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_cs_we_after", 32'({cs0, swe0, cs1, swe1}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rst_readies = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ready0 || ready1) rst_readies++;
        end
        check("arst_no_ready", 32'(rst_readies), 32'd0);

        txn(32'h0001_0010, 4'b0000, 32'h0);
        check("arst_no_write", rd0, 32'h0);
        check("arst_next_lat0", 32'(lat0), 32'd3);
        txn(32'h0001_0004, 4'b0000, 32'h0);
        check("post_rd0", rd0, 32'hDEAD_AAEF);
        check("post_lat1", 32'(lat1), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 0, extra response-delay cycles (legal 0..15).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0001_0000, byte address of first SRAM word.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, SRAM depth in 32-bit words (power of two).
REQ-004 SHALL have one clock and one reset; reset is asynchronous, active-low.
REQ-005 SHALL have port clk, input, 1, clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port dmem_valid_i, input, 1, request from the load/store unit.
REQ-008 SHALL have port dmem_ready_o, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port dmem_addr_i, input, RISCV_ADDR_WIDTH, byte address.
REQ-010 SHALL have port dmem_wdata_i, input, RISCV_WORD_WIDTH, lane-aligned write data.
REQ-011 SHALL have port dmem_we_i, input, 4, byte-lane write enables (bit 3 = lane [31:24] = byte addr+0); 0 = read.
REQ-012 SHALL have port dmem_rdata_o, output, RISCV_WORD_WIDTH, read data, same lane order.
REQ-013 SHALL have port dmem_err_o, output, 1, access fault, valid with dmem_ready_o.
REQ-014 SHALL have port sram_cs_o, output, 1, SRAM chip select.
REQ-015 SHALL have port sram_we_o, output, 4, SRAM byte write enables, same lane order.
REQ-016 SHALL have port sram_addr_o, output, $clog2(DEPTH_WORDS), SRAM word index.
REQ-017 SHALL have port sram_wdata_o, output, RISCV_WORD_WIDTH, SRAM write data.
REQ-018 SHALL have port sram_rdata_i, input, RISCV_WORD_WIDTH, SRAM read data, valid the cycle after sram_cs_o.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, CAPTURE, WAIT, RESP.
REQ-020 IDLE with dmem_valid_i=1 SHALL latch addr, wdata, we into request registers on that edge.
REQ-021 In-range (BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS, unsigned, no overflow wrap) SHALL go IDLE->ACCESS; out-of-range SHALL go IDLE->RESP with error flag set, no SRAM access.
REQ-022 ACCESS SHALL drive sram_cs_o=1, sram_we_o=latched we, sram_addr_o=(addr-BASE_ADDR)>>2, sram_wdata_o=latched wdata for exactly one cycle, then ->CAPTURE.
REQ-023 CAPTURE SHALL register sram_rdata_i into rdata_q, then ->WAIT if WAIT_CYCLES>0 else ->RESP.
REQ-024 WAIT SHALL count WAIT_CYCLES cycles with a 4-bit down-counter, then ->RESP.
REQ-025 RESP SHALL assert dmem_ready_o=1 for exactly one cycle, then ->IDLE unconditionally.
REQ-026 In-range latency: request sampled at edge N -> dmem_ready_o high in cycle N+3+WAIT_CYCLES; error latency: cycle N+1.
REQ-027 dmem_rdata_o SHALL be rdata_q in RESP for in-range reads, else 32'h0.
REQ-028 dmem_err_o SHALL equal error flag in RESP, else 0.
REQ-029 Address bits [1:0] SHALL be ignored for SRAM indexing; any nonzero dmem_we_i pattern SHALL be a write.
REQ-030 Input changes or dmem_valid_i deassertion after latching SHALL be ignored; transaction completes and ready still pulses.
REQ-031 Request held high through RESP SHALL NOT be re-accepted in RESP; next accept earliest in IDLE cycle after RESP.
REQ-032 sram_cs_o, sram_we_o SHALL be 0 in all states except ACCESS.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, clear request registers, rdata_q, error flag, counter; all outputs 0.
REQ-034 Reset during ACCESS SHALL deassert sram_cs_o/sram_we_o asynchronously; no ready pulse follows.

Verification
REQ-035 Write addr 32'h0001_0004, we 4'b1111, wdata 32'hDEAD_BEEF -> cs at N+1, sram_addr 1, ready at N+3, err 0, rdata 0.
REQ-036 Read same address, WAIT_CYCLES=0 -> ready at N+3, rdata 32'hDEAD_BEEF; WAIT_CYCLES=2 -> ready at N+5.
REQ-037 Byte write addr 32'h0001_0006, we 4'b0010, wdata 32'h0000_AA00 -> only lane [15:8] written; read back 32'hDEAD_AAEF.
REQ-038 Read addr 32'h0000_FFFC and 32'h0001_1000 (DEPTH 1024) -> ready at N+1, err 1, rdata 0, sram_cs_o never high.
REQ-039 Valid held high 3 back-to-back reads -> exactly one ready per access, one IDLE bubble between, no duplicate accesses.
REQ-040 rst_n pulsed low during ACCESS of a write -> sram_cs_o drops same cycle, FSM IDLE, no ready, next request normal.
